// File: rtl/dispatch_rr_arbiter_pkg.sv
// Shared types for the dispatch arbiters: the flattened dispatch record and
// the grant-index width helper.
package dispatch_rr_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int NUM_THREADS = 4;
  localparam int NUM_WARPS   = 16;

  typedef struct packed {
    logic [31:0]                 uuid;
    logic [$clog2(NUM_WARPS)-1:0] wis;
    logic [NUM_THREADS-1:0]      tmask;
    logic [XLEN-1:0]             pc;
    logic [3:0]                  op_type;
    logic [7:0]                  op_args;
    logic                        wb;
    logic [4:0]                  rd;
    logic [1:0]                  tid;
    logic [NUM_THREADS*XLEN-1:0] rs1_data;
    logic [NUM_THREADS*XLEN-1:0] rs2_data;
    logic [NUM_THREADS*XLEN-1:0] rs3_data;
    logic [3:0]                  infl_id;
  } dispatch_data_t;

  localparam int DATAW = $bits(dispatch_data_t);

  // Grant-index width; a single requester still needs a 1-bit index.
  function automatic int arb_rr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ARB_RR_W = arb_rr_w(4);

endpackage

// File: rtl/dispatch_rr_arbiter_if.sv
// Request side and shared-port side of the dispatch arbiter.
interface dispatch_rr_arbiter_if #(
  parameter int NUM_REQS = 4
);
  import dispatch_rr_arbiter_pkg::*;

  localparam int REQ_W = arb_rr_w(NUM_REQS);

  logic [NUM_REQS-1:0]       req_valid;
  logic [NUM_REQS*DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]       req_ready;
  logic                      out_valid;
  dispatch_data_t            out_data;
  logic [REQ_W-1:0]          out_sel;
  logic                      out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/dispatch_rr_arbiter_picker.sv
// Rotate-priority encoder: first valid index at or after ptr_i, wrapping.
module dispatch_rr_picker #(
  parameter int NUM_REQS = 4,
  parameter int REQ_W    = 2
) (
  input  logic [NUM_REQS-1:0] valid_i,
  input  logic [REQ_W-1:0]    ptr_i,
  output logic [REQ_W-1:0]    pick_o,
  output logic                any_o
);

  always_comb begin
    logic [REQ_W:0] idx;
    pick_o = '0;
    any_o  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      // Explicit wrap keeps non-power-of-two counts free of a modulo.
      idx = {1'b0, ptr_i} + (REQ_W+1)'(k);
      if (idx >= (REQ_W+1)'(NUM_REQS)) idx = idx - (REQ_W+1)'(NUM_REQS);
      if (!any_o && valid_i[idx[REQ_W-1:0]]) begin
        any_o  = 1'b1;
        pick_o = idx[REQ_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dispatch_rr_arbiter.sv
// Round-robin arbiter sharing one dispatch port among NUM_REQS slices,
// with a single registered output stage.
module dispatch_rr_arbiter
  import dispatch_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dispatch_rr_arbiter_if.slave bus_if
);

  localparam int REQ_W = arb_rr_w(NUM_REQS);

  logic [REQ_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [REQ_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  dispatch_data_t   out_data_q, out_data_d;
  logic [REQ_W-1:0] pick;
  logic             any_valid;
  logic             load;
  logic             xfer;

  dispatch_rr_picker #(
    .NUM_REQS (NUM_REQS),
    .REQ_W    (REQ_W)
  ) u_picker (
    .valid_i (bus_if.req_valid),
    .ptr_i   (rr_ptr_q),
    .pick_o  (pick),
    .any_o   (any_valid)
  );

  assign load = ~out_valid_q | bus_if.out_ready;
  // Gated by reset so no slice sees an accept while the stage is being cleared.
  assign xfer = load & any_valid & ~reset;

  always_comb begin
    bus_if.req_ready = '0;
    if (xfer) bus_if.req_ready[pick] = 1'b1;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      if (any_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = dispatch_data_t'(bus_if.req_data[int'(pick)*DATAW +: DATAW]);
        out_sel_d   = pick;
        rr_ptr_d    = (pick == REQ_W'(NUM_REQS-1)) ? '0 : pick + REQ_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output stage register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_data  = out_data_q;
  assign bus_if.out_sel   = out_sel_q;

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus_if.req_ready));
  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid_q && !bus_if.out_ready) |=> ($stable(out_data_q) && $stable(out_sel_q)));
`endif

endmodule

// File: tb/tb_dispatch_rr_arbiter.sv
// Directed bench for dispatch_rr_arbiter plus a short randomized ordering soak.
module tb_dispatch_rr_arbiter;
  import dispatch_rr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dispatch_rr_arbiter_if #(.NUM_REQS(4)) bus ();

  dispatch_rr_arbiter #(.NUM_REQS(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  function automatic dispatch_data_t mk_rec(input logic [31:0] uuid);
    dispatch_data_t r;
    r          = '0;
    r.uuid     = uuid;
    r.wis      = uuid[3:0];
    r.tmask    = ~uuid[3:0];
    r.pc       = uuid * 4 + 32'h8000_0000;
    r.op_type  = uuid[7:4];
    r.op_args  = uuid[7:0] ^ 8'hA5;
    r.wb       = uuid[0];
    r.rd       = uuid[4:0];
    r.tid      = uuid[1:0];
    r.rs1_data = {4{uuid}};
    r.rs2_data = {4{~uuid}};
    r.rs3_data = {4{uuid ^ 32'h5A5A_5A5A}};
    r.infl_id  = uuid[5:2];
    return r;
  endfunction

  task automatic set_slice(input int i, input logic [31:0] uuid);
    bus.req_data[i*DATAW +: DATAW] = mk_rec(uuid);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus.req_valid = '0;
    #2;
    step;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_slice(i, 32'h10 + i);
    bus.req_valid = 4'b1111;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", bus.req_ready); end
    total++; if (bus.out_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", bus.out_sel); end
    total++; if (bus.out_data !== dispatch_data_t'('0)) begin bad++; $display("FAIL reset_data uuid got=%h want=0", bus.out_data.uuid); end
    step;
    step;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid got=%b want=0", bus.out_valid); end
    reset = 1'b0;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_ready got=%b want=0001", bus.req_ready); end
    step;
    total++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0) begin
      bad++; $display("FAIL reset_first_grant valid=%b sel=%0d want valid=1 sel=0", bus.out_valid, bus.out_sel); end
    total++; if (bus.out_data !== mk_rec(32'h10)) begin bad++; $display("FAIL reset_first_data uuid got=%h want=10", bus.out_data.uuid); end
    bus.req_valid = '0;
    step;
  endtask

  task automatic test_rotation;
    do_reset;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(k % 4) || bus.out_data !== mk_rec(32'h10 + k % 4)) begin
        bad++;
        $display("FAIL rotation[%0d] valid=%b sel=%0d uuid=%h want valid=1 sel=%0d uuid=%h",
                 k, bus.out_valid, bus.out_sel, bus.out_data.uuid, k % 4, 32'h10 + k % 4);
      end
    end
    bus.req_valid = '0;
    step;
  endtask

  task automatic test_skip_wrap;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0100;
    step;
    total++; if (bus.out_sel !== 2'd2) begin bad++; $display("FAIL skip_setup sel got=%0d want=2", bus.out_sel); end
    bus.req_valid = 4'b0110;
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL skip_ready_ptr3 got=%b want=0010", bus.req_ready); end
    step;
    total++; if (bus.out_sel !== 2'd1 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL skip_grant1 sel=%0d valid=%b want sel=1 valid=1", bus.out_sel, bus.out_valid); end
    #1;
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL skip_ready_ptr2 got=%b want=0100", bus.req_ready); end
    step;
    total++; if (bus.out_sel !== 2'd2) begin bad++; $display("FAIL skip_grant2 sel got=%0d want=2", bus.out_sel); end
    bus.req_valid = 4'b1111;
    #1;
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL skip_ptr_wrap3 ready got=%b want=1000", bus.req_ready); end
    bus.req_valid = '0;
    step;
  endtask

  task automatic test_backpressure;
    set_slice(3, 32'h2A);
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1000;
    step;
    total++; if (bus.out_data.uuid !== 32'h2A || bus.out_sel !== 2'd3) begin bad++; $display("FAIL bp_load uuid=%h sel=%0d want uuid=2a sel=3", bus.out_data.uuid, bus.out_sel); end
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0000", k, bus.req_ready); end
      step;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== mk_rec(32'h2A) || bus.out_sel !== 2'd3) begin
        bad++; $display("FAIL bp_hold[%0d] valid=%b uuid=%h sel=%0d want valid=1 uuid=2a sel=3", k, bus.out_valid, bus.out_data.uuid, bus.out_sel);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_release_ready got=%b want=0001", bus.req_ready); end
    step;
    total++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== mk_rec(32'h10)) begin
      bad++; $display("FAIL bp_release_load valid=%b sel=%0d uuid=%h want valid=1 sel=0 uuid=10", bus.out_valid, bus.out_sel, bus.out_data.uuid); end
    bus.req_valid = '0;
    step;
    set_slice(3, 32'h13);
  endtask

  task automatic test_idle_drain;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0100;
    step;
    total++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2) begin bad++; $display("FAIL drain_beat valid=%b sel=%0d want valid=1 sel=2", bus.out_valid, bus.out_sel); end
    bus.req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      step;
      total++; if (bus.out_valid !== 1'b0 || bus.out_sel !== 2'd2) begin
        bad++; $display("FAIL drain_idle[%0d] valid=%b sel=%0d want valid=0 sel=2", k, bus.out_valid, bus.out_sel); end
    end
  endtask

  task automatic test_mid_reset;
    set_slice(0, 32'h55);
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0001;
    step;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data.uuid !== 32'h55) begin bad++; $display("FAIL midrst_load valid=%b uuid=%h want valid=1 uuid=55", bus.out_valid, bus.out_data.uuid); end
    bus.out_ready = 1'b0;
    bus.req_valid = '0;
    step;
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== dispatch_data_t'('0)) begin
      bad++; $display("FAIL midrst_clear valid=%b uuid=%h want valid=0 uuid=0", bus.out_valid, bus.out_data.uuid); end
    step;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_after[%0d] valid got=%b want=0", k, bus.out_valid); end
    end
    set_slice(0, 32'h10);
  endtask

  task automatic test_soak;
    int sent [4];
    int rcvd [4];
    logic [3:0] acc;
    int s;
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      rcvd[i] = 0;
      set_slice(i, (i << 16));
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) bus.req_valid[i] = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = bus.req_valid & bus.req_ready;
      if (bus.out_valid && bus.out_ready) begin
        s = int'(bus.out_sel);
        total++;
        if (bus.out_data !== mk_rec((s << 16) | rcvd[s])) begin
          bad++; $display("FAIL soak_order sel=%0d uuid=%h want=%h", s, bus.out_data.uuid, (s << 16) | rcvd[s]);
        end
        rcvd[s]++;
      end
      step;
      for (int i = 0; i < 4; i++) if (acc[i]) begin
        sent[i]++;
        set_slice(i, (i << 16) | sent[i]);
      end
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        s = int'(bus.out_sel);
        total++;
        if (bus.out_data !== mk_rec((s << 16) | rcvd[s])) begin
          bad++; $display("FAIL soak_drain sel=%0d uuid=%h want=%h", s, bus.out_data.uuid, (s << 16) | rcvd[s]);
        end
        rcvd[s]++;
      end
      step;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rcvd[i] !== sent[i]) begin bad++; $display("FAIL soak_count slice=%0d rcvd=%0d sent=%0d", i, rcvd[i], sent[i]); end
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    test_reset;
    test_rotation;
    test_skip_wrap;
    test_backpressure;
    test_idle_drain;
    test_mid_reset;
    test_soak;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
